tree_mac_accum: RTL and testbench

- Sits directly downstream of the tree adder in the tree MAC datapath.
- Consumes the adder's per-beat partial sums, which are tagged with addr_i/addr_k, and accumulates NUM_K_BLOCKS consecutive k-beats of the same row i into one wide dot-product result.
- Completed results are buffered in a small FIFO with a valid/ready output, because the upstream adder cannot be stalled.
- Detects malformed k sequences and buffer overflow.

---
 rtl/tree_mac_accum.sv | 161 ++++++++++++++++
 tb/tb_tree_mac_accum.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tree_mac_accum.sv
// Accumulates NUM_K_BLOCKS tagged partial sums per row into one wide result and
// buffers completed results in a small valid/ready FIFO (no upstream stall).
module tree_mac_accum #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned ACC_WIDTH       = 16,
  parameter int unsigned ADDRESS_WIDTH_I = 8,
  parameter int unsigned ADDRESS_WIDTH_K = 8,
  parameter int unsigned NUM_K_BLOCKS    = 4,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        sum_in,
  input  logic [ADDRESS_WIDTH_I-1:0]   addr_i_in,
  input  logic [ADDRESS_WIDTH_K-1:0]   addr_k_in,
  input  logic                         val_in,
  output logic [ACC_WIDTH-1:0]         acc_out,
  output logic [ADDRESS_WIDTH_I-1:0]   addr_i_out,
  output logic                         val_out,
  input  logic                         rdy_in,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow,
  output logic                         seq_err
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [ADDRESS_WIDTH_K-1:0] K_LAST = ADDRESS_WIDTH_K'(NUM_K_BLOCKS - 1);

  typedef enum logic {IDLE, ACCUM} state_e;

  state_e                       state_q, state_d;
  logic [ACC_WIDTH-1:0]         acc_q, acc_d;
  logic [ADDRESS_WIDTH_I-1:0]   cur_i_q, cur_i_d;
  logic [ADDRESS_WIDTH_K-1:0]   exp_k_q, exp_k_d;
  logic                         seq_err_q, seq_err_d;
  logic                         overflow_q, overflow_d;
  logic [PW-1:0]                rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]                count_q, count_d, count_after_pop;
  logic                         val_out_q, val_out_d;
  logic [ACC_WIDTH-1:0]         head_acc_q, head_acc_d;
  logic [ADDRESS_WIDTH_I-1:0]   head_i_q, head_i_d;

  logic [ACC_WIDTH-1:0]         mem_acc_q [FIFO_DEPTH];
  logic [ADDRESS_WIDTH_I-1:0]   mem_i_q   [FIFO_DEPTH];

  logic [ACC_WIDTH-1:0]         sum_ext;
  logic                         push, pop, full, wr_en;
  logic [ACC_WIDTH-1:0]         push_acc;
  logic [ADDRESS_WIDTH_I-1:0]   push_i;

  assign sum_ext = ACC_WIDTH'($signed(sum_in));

  // Beat sequencing: k=0 always (re)starts a group, in-order beats accumulate.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cur_i_d   = cur_i_q;
    exp_k_d   = exp_k_q;
    seq_err_d = seq_err_q;
    push      = 1'b0;
    push_acc  = acc_q;
    push_i    = cur_i_q;
    if (val_in) begin
      if (addr_k_in == '0) begin
        if (state_q == ACCUM) seq_err_d = 1'b1;
        acc_d    = sum_ext;
        cur_i_d  = addr_i_in;
        push_acc = sum_ext;
        push_i   = addr_i_in;
        if (K_LAST == '0) begin
          push    = 1'b1;
          state_d = IDLE;
          exp_k_d = '0;
        end else begin
          state_d = ACCUM;
          exp_k_d = ADDRESS_WIDTH_K'(1);
        end
      end else if (state_q == ACCUM && addr_k_in == exp_k_q && addr_i_in == cur_i_q) begin
        acc_d    = acc_q + sum_ext;
        push_acc = acc_q + sum_ext;
        if (addr_k_in == K_LAST) begin
          push    = 1'b1;
          state_d = IDLE;
          exp_k_d = '0;
        end else begin
          exp_k_d = exp_k_q + ADDRESS_WIDTH_K'(1);
        end
      end else begin
        seq_err_d = 1'b1;
      end
    end
  end

  // FIFO bookkeeping; the head is re-registered so outputs come straight from flops.
  always_comb begin
    pop             = val_out_q && rdy_in;
    full            = (count_q == CW'(FIFO_DEPTH));
    wr_en           = push && (!full || pop);
    overflow_d      = overflow_q | (push && full && !pop);
    count_after_pop = count_q - CW'(pop);
    count_d         = count_after_pop + CW'(wr_en);
    rd_ptr_d        = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d        = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    val_out_d       = (count_d != '0);
    head_acc_d      = head_acc_q;
    head_i_d        = head_i_q;
    if (count_after_pop != '0) begin
      head_acc_d = mem_acc_q[rd_ptr_d];
      head_i_d   = mem_i_q[rd_ptr_d];
    end else if (wr_en) begin
      head_acc_d = push_acc;
      head_i_d   = push_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cur_i_q    <= '0;
      exp_k_q    <= '0;
      seq_err_q  <= 1'b0;
      overflow_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      val_out_q  <= 1'b0;
      head_acc_q <= '0;
      head_i_q   <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cur_i_q    <= cur_i_d;
      exp_k_q    <= exp_k_d;
      seq_err_q  <= seq_err_d;
      overflow_q <= overflow_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      val_out_q  <= val_out_d;
      head_acc_q <= head_acc_d;
      head_i_q   <= head_i_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_acc_q[wr_ptr_q] <= push_acc;
      mem_i_q[wr_ptr_q]   <= push_i;
    end
  end

  assign acc_out    = head_acc_q;
  assign addr_i_out = head_i_q;
  assign val_out    = val_out_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_tree_mac_accum.sv
// Bench for tree_mac_accum: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference model of the accumulate/buffer rules.
module tb_tree_mac_accum;

  localparam int unsigned NK    = 4;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  sum_in, addr_i_in, addr_k_in;
  logic        val_in, rdy_in;
  logic [15:0] acc_out;
  logic [7:0]  addr_i_out;
  logic        val_out, overflow, seq_err;
  logic [2:0]  fifo_count;

  tree_mac_accum dut (
    .clk(clk), .reset(reset), .sum_in(sum_in), .addr_i_in(addr_i_in),
    .addr_k_in(addr_k_in), .val_in(val_in), .acc_out(acc_out),
    .addr_i_out(addr_i_out), .val_out(val_out), .rdy_in(rdy_in),
    .fifo_count(fifo_count), .overflow(overflow), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [15:0] q_acc[$];
  logic [7:0]  q_i[$];
  bit          m_busy;
  logic [15:0] m_acc;
  logic [7:0]  m_cur, m_exp;
  bit          m_seq, m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_acc.delete(); q_i.delete();
    m_busy = 0; m_acc = '0; m_cur = '0; m_exp = '0; m_seq = 0; m_ovf = 0;
  endtask

  task automatic model_edge(input bit v, input logic [7:0] i, input logic [7:0] k,
                            input logic [7:0] s, input bit r);
    logic [15:0] sx;
    bit          done;
    sx   = {{8{s[7]}}, s};
    done = 0;
    if (v) begin
      if (k == 0) begin
        if (m_busy) m_seq = 1;
        m_acc = sx; m_cur = i; m_exp = 1; m_busy = 1;
        if (NK == 1) done = 1;
      end else if (m_busy && k == m_exp && i == m_cur) begin
        m_acc = m_acc + sx;
        m_exp = m_exp + 1;
        if (k == 8'(NK - 1)) done = 1;
      end else begin
        m_seq = 1;
      end
    end
    if (q_acc.size() > 0 && r) begin
      void'(q_acc.pop_front());
      void'(q_i.pop_front());
    end
    if (done) begin
      m_busy = 0; m_exp = 0;
      if (q_acc.size() < DEPTH) begin
        q_acc.push_back(m_acc);
        q_i.push_back(m_cur);
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("val_out", 32'(val_out), 32'(q_acc.size() != 0));
    check("fifo_count", 32'(fifo_count), 32'(q_acc.size()));
    check("seq_err", 32'(seq_err), 32'(m_seq));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (q_acc.size() != 0) begin
      check("acc_out", 32'(acc_out), 32'(q_acc[0]));
      check("addr_i_out", 32'(addr_i_out), 32'(q_i[0]));
    end
  endtask

  task automatic cyc(input bit v, input logic [7:0] i, input logic [7:0] k,
                     input logic [7:0] s, input bit r);
    val_in = v; addr_i_in = i; addr_k_in = k; sum_in = s; rdy_in = r;
    @(posedge clk);
    model_edge(v, i, k, s, r);
    #1;
    compare_all();
  endtask

  // Called just after a rising edge; checks the asynchronous effect before the next edge.
  task automatic do_reset();
    val_in = 0; rdy_in = 0;
    reset = 1;
    #2;
    check("rst_val_out", 32'(val_out), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_seq_err", 32'(seq_err), 32'd0);
    check("rst_acc_out", 32'(acc_out), 32'd0);
    check("rst_addr_i_out", 32'(addr_i_out), 32'd0);
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
  endtask

  task automatic group(input logic [7:0] i, input logic [7:0] s0, input logic [7:0] s1,
                       input logic [7:0] s2, input logic [7:0] s3, input bit r);
    cyc(1, i, 8'd0, s0, r);
    cyc(1, i, 8'd1, s1, r);
    cyc(1, i, 8'd2, s2, r);
    cyc(1, i, 8'd3, s3, r);
  endtask

  initial begin
    reset = 1; val_in = 0; rdy_in = 0; sum_in = '0; addr_i_in = '0; addr_k_in = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Basic group
    group(8'd3, 8'd10, 8'd20, 8'd30, 8'd40, 1'b1);
    check("basic_acc", 32'(acc_out), 32'd100);
    check("basic_addr", 32'(addr_i_out), 32'd3);
    check("basic_val", 32'(val_out), 32'd1);
    cyc(0, 8'd0, 8'd0, 8'd0, 1'b1);
    check("basic_val_drop", 32'(val_out), 32'd0);

    // Sign extension and wrap
    group(8'd1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    check("sext_neg", 32'(acc_out), 32'h0000FFFC);
    group(8'd1, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b1);
    check("sext_pos", 32'(acc_out), 32'h000001FC);
    cyc(0, 8'd0, 8'd0, 8'd0, 1'b1);

    // Backpressure and overflow
    for (int n = 1; n <= 5; n++)
      group(8'(n - 1), 8'(n), 8'd0, 8'd0, 8'd0, 1'b0);
    check("ovf_count", 32'(fifo_count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_head", 32'(acc_out), 32'd1);
    for (int n = 0; n < 4; n++) cyc(0, 8'd0, 8'd0, 8'd0, 1'b1);
    check("drain_empty", 32'(val_out), 32'd0);

    // Reset mid-group with results still buffered
    group(8'd9, 8'd5, 8'd5, 8'd5, 8'd5, 1'b0);
    cyc(1, 8'd2, 8'd0, 8'd7, 1'b0);
    cyc(1, 8'd2, 8'd1, 8'd7, 1'b0);
    do_reset();
    group(8'd2, 8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
    check("rst_group_acc", 32'(acc_out), 32'd10);

    // Sequence error
    cyc(1, 8'd6, 8'd0, 8'd1, 1'b1);
    cyc(1, 8'd6, 8'd1, 8'd2, 1'b1);
    cyc(1, 8'd6, 8'd3, 8'd99, 1'b1);
    check("seq_err_set", 32'(seq_err), 32'd1);
    cyc(1, 8'd6, 8'd2, 8'd3, 1'b1);
    cyc(1, 8'd6, 8'd3, 8'd4, 1'b1);
    check("seq_acc", 32'(acc_out), 32'd10);
    cyc(0, 8'd0, 8'd0, 8'd0, 1'b1);
    @(posedge clk);
    #1;
    do_reset();

    // Bubbles and simultaneous push/pop while full
    for (int n = 0; n < 4; n++)
      group(8'(n), 8'(11 + n), 8'd0, 8'd0, 8'd0, 1'b0);
    cyc(1, 8'd7, 8'd0, 8'd1, 1'b0);
    cyc(0, 8'd0, 8'd0, 8'd0, 1'b0);
    cyc(1, 8'd7, 8'd1, 8'd2, 1'b0);
    cyc(0, 8'd0, 8'd0, 8'd0, 1'b0);
    cyc(0, 8'd0, 8'd0, 8'd0, 1'b0);
    cyc(1, 8'd7, 8'd2, 8'd3, 1'b0);
    cyc(0, 8'd0, 8'd0, 8'd0, 1'b0);
    cyc(1, 8'd7, 8'd3, 8'd4, 1'b1);
    check("full_pp_count", 32'(fifo_count), 32'd4);
    check("full_pp_ovf", 32'(overflow), 32'd0);
    check("full_pp_head", 32'(acc_out), 32'd12);
    for (int n = 0; n < 4; n++) cyc(0, 8'd0, 8'd0, 8'd0, 1'b1);
    check("full_pp_last", 32'(acc_out), 32'd10);
    cyc(0, 8'd0, 8'd0, 8'd0, 1'b1);
    @(posedge clk);
    #1;
    do_reset();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      bit          v, r;
      logic [7:0]  i, k;
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      k = m_busy ? m_exp : 8'd0;
      i = m_busy ? m_cur : 8'($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) k = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 15) == 0) i = 8'($urandom_range(0, 3));
      cyc(v, i, k, 8'($urandom), r);
      if (c == 300) begin
        @(posedge clk);
        #1;
        do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
